// File: rtl/kbd_scan_ctrl.sv
// 4x4 keypad scanner: column-sequenced sampling, per-key debounce and a
// 4-entry press-event FIFO with sticky overflow.
module kbd_scan_ctrl #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic [15:0] key_down,
  output logic        overflow,
  input  logic        ovf_clr
);

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_CHECK   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_t;

  // SCAN_DIV >= 4 keeps the counter at least 2 bits wide, enough for the row index in CHECK.
  localparam int            CW          = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N       = 4'(DEBOUNCE);

  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_sync;
  logic [3:0]    r_snap;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_col_idx;
  logic [1:0]    w_col_idx_nxt;
  logic          w_snap_en;
  logic          w_check_en;

  logic [1:0]    w_row;
  logic [3:0]    w_code;
  logic          w_raw;
  logic [3:0]    r_deb_cnt [16];
  logic [3:0]    w_deb_inc;
  logic [15:0]   r_key_down;
  logic          w_toggle;
  logic          w_push;

  logic [3:0]    r_fifo [4];
  logic [1:0]    r_wr_ptr;
  logic [1:0]    r_rd_ptr;
  logic [2:0]    r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;
  logic          r_ovf;

  // Rows are asynchronous to clk; idle level is high (no key pressed).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_SETTLE;
      r_cnt     <= '0;
      r_col_idx <= '0;
      r_snap    <= '1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_col_idx <= w_col_idx_nxt;
      if (w_snap_en) r_snap <= r_row_sync;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_col_idx_nxt = r_col_idx;
    w_snap_en     = 1'b0;
    w_check_en    = 1'b0;
    unique case (r_state)
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = '0;
          w_snap_en   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        w_check_en = 1'b1;
        if (r_cnt[1:0] == 2'd3) begin
          w_state_nxt = ST_ADVANCE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ADVANCE: begin
        w_state_nxt   = ST_SETTLE;
        w_cnt_nxt     = '0;
        w_col_idx_nxt = r_col_idx + 1'b1;
      end
      default: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // During CHECK the low counter bits select the row; code = 4*row + col.
  assign w_row     = r_cnt[1:0];
  assign w_code    = {w_row, r_col_idx};
  assign w_raw     = ~r_snap[w_row];
  assign w_deb_inc = r_deb_cnt[w_code] + 4'd1;

  always_comb begin
    w_toggle = 1'b0;
    w_push   = 1'b0;
    if (w_check_en && (w_raw != r_key_down[w_code]) && (w_deb_inc == DEB_N)) begin
      w_toggle = 1'b1;
      w_push   = w_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_deb_cnt[i] <= '0;
      r_key_down <= '0;
    end else if (w_check_en) begin
      if (w_raw == r_key_down[w_code]) begin
        r_deb_cnt[w_code] <= '0;
      end else if (w_toggle) begin
        r_deb_cnt[w_code]  <= '0;
        r_key_down[w_code] <= w_raw;
      end else begin
        r_deb_cnt[w_code] <= w_deb_inc;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_full    = (r_count == 3'd4);
  assign w_pop     = key_valid && key_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // NOTE: the FIFO storage is reset because key_code must read 0 while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= w_code;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= 1'b0;
    else     r_ovf <= w_drop | (r_ovf & ~ovf_clr);
  end

  assign col_out   = ~(4'b0001 << r_col_idx);
  assign key_valid = (r_count != 3'd0);
  assign key_code  = r_fifo[r_rd_ptr];
  assign key_down  = r_key_down;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: a keypad matrix model drives row_in from
// col_out, and a cycle-level reference model of the scan/debounce/FIFO rules is compared every cycle.
module tb_kbd_scan_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 2;
  localparam int PERIOD   = SCAN_DIV + 5;
  localparam int SCAN     = 4 * PERIOD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b1;
  logic [15:0] key_down;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;

  kbd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Physical matrix: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] col_for(input int n);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << ((n / PERIOD) % 4);
    return ~one_hot;
  endfunction

  // Reference model: edge n after reset release; edge n with n%PERIOD==SCAN_DIV snapshots
  // the row value seen two edges earlier, the next four edges process rows 0..3.
  int          m_n = 0;
  logic [3:0]  m_h1 = '1;
  logic [3:0]  m_h2 = '1;
  logic [3:0]  m_snap = '1;
  int          m_cnt [16];
  logic [15:0] m_down = '0;
  int          m_q [$];
  logic        m_ovf = 1'b0;

  always @(posedge clk) begin
    int p, c, r, code, ev;
    bit pop, drop, raw;
    if (rst) begin
      m_n = 0; m_h1 = '1; m_h2 = '1; m_snap = '1;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_down = '0; m_q.delete(); m_ovf = 1'b0;
    end else begin
      pop  = (m_q.size() != 0) && key_ready;
      ev   = -1;
      drop = 1'b0;
      m_n++;
      p = m_n % PERIOD;
      c = (m_n / PERIOD) % 4;
      if (p == SCAN_DIV) begin
        m_snap = m_h2;
      end else if (p > SCAN_DIV) begin
        r    = p - SCAN_DIV - 1;
        code = 4 * r + c;
        raw  = !m_snap[r];
        if (raw == m_down[code]) m_cnt[code] = 0;
        else begin
          m_cnt[code]++;
          if (m_cnt[code] == DEBOUNCE) begin
            m_cnt[code]  = 0;
            m_down[code] = raw;
            if (raw) ev = code;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = row_in;
      if (pop) void'(m_q.pop_front());
      if (ev >= 0) begin
        if (m_q.size() < 4) m_q.push_back(ev);
        else drop = 1'b1;
      end
      m_ovf = drop || (m_ovf && !ovf_clr);
    end
  end

  always @(negedge clk) begin
    check("model_col_out", col_out, col_for(m_n));
    check("model_key_valid", key_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("model_key_code", key_code, m_q[0]);
    check("model_key_down", key_down, m_down);
    check("model_overflow", overflow, m_ovf);
  end

  typedef struct {
    int         edge_n;
    logic [3:0] col;
  } col_vec_t;

  typedef struct {
    int code;
    int hold;
    int exp_events;
    bit exp_seen;
  } key_vec_t;

  col_vec_t col_tab [9];
  key_vec_t key_tab [5];
  int       bp_codes [5];
  int       bp_exp [4];

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic run_col_table();
    for (int i = 0; i < 9; i++) begin
      for (int w = 0; w < 2 * SCAN && m_n < col_tab[i].edge_n; w++) @(negedge clk);
      check("col_step", col_out, col_tab[i].col);
    end
  endtask

  task automatic run_key(input key_vec_t v);
    int events;
    bit seen;
    events    = 0;
    seen      = 1'b0;
    key_ready = 1'b1;
    keys      = '0;
    keys[v.code] = 1'b1;
    for (int i = 0; i < v.hold + 3 * SCAN; i++) begin
      if (i == v.hold) keys = '0;
      @(negedge clk);
      if (key_down[v.code]) seen = 1'b1;
      if (key_valid) begin
        events++;
        check("key_event_code", key_code, v.code);
      end
    end
    check("key_event_count", events, v.exp_events);
    check("key_seen_down", seen, v.exp_seen);
    check("key_released", key_down, 16'h0000);
  endtask

  task automatic press_release(input int code, input int hold);
    keys = '0;
    keys[code] = 1'b1;
    cycles(hold);
    keys = '0;
    cycles(hold);
  endtask

  initial begin
    col_tab[0] = '{1,  4'b1110};
    col_tab[1] = '{12, 4'b1110};
    col_tab[2] = '{13, 4'b1101};
    col_tab[3] = '{25, 4'b1101};
    col_tab[4] = '{26, 4'b1011};
    col_tab[5] = '{38, 4'b1011};
    col_tab[6] = '{39, 4'b0111};
    col_tab[7] = '{51, 4'b0111};
    col_tab[8] = '{52, 4'b1110};

    key_tab[0] = '{9,  300,      1, 1'b1};
    key_tab[1] = '{3,  SCAN,     0, 1'b0};
    key_tab[2] = '{6,  2 * SCAN, 1, 1'b1};
    key_tab[3] = '{15, 40,       0, 1'b0};
    key_tab[4] = '{12, 3 * SCAN, 1, 1'b1};

    bp_codes = '{1, 4, 7, 10, 13};
    bp_exp   = '{1, 4, 7, 10};

    // Reset state and column stepping after release.
    cycles(3);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 16'h0000);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    run_col_table();

    for (int i = 0; i < 5; i++) run_key(key_tab[i]);

    // Backpressure: four events held, fifth dropped.
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) press_release(bp_codes[i], 150);
    check("bp_full_valid", key_valid, 1'b1);
    check("bp_overflow_set", overflow, 1'b1);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_pop_valid", key_valid, 1'b1);
      check("bp_pop_code", key_code, bp_exp[i]);
      @(negedge clk);
    end
    check("bp_drained", key_valid, 1'b0);
    check("bp_overflow_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("bp_overflow_cleared", overflow, 1'b0);

    // Two rows of one column: rows ascending in the event order.
    key_ready = 1'b0;
    keys = '0;
    keys[0]  = 1'b1;
    keys[12] = 1'b1;
    cycles(150);
    keys = '0;
    cycles(150);
    check("col_pair_valid0", key_valid, 1'b1);
    check("col_pair_code0", key_code, 4'd0);
    key_ready = 1'b1;
    @(negedge clk);
    check("col_pair_valid1", key_valid, 1'b1);
    check("col_pair_code1", key_code, 4'd12);
    @(negedge clk);
    check("col_pair_empty", key_valid, 1'b0);

    // Random keys, ready and clears against the reference model.
    for (int seg = 0; seg < 20; seg++) begin
      int dur;
      keys = '0;
      case ($urandom_range(0, 3))
        0:       keys = '0;
        3: begin
          keys[$urandom_range(0, 15)] = 1'b1;
          keys[$urandom_range(0, 15)] = 1'b1;
        end
        default: keys[$urandom_range(0, 15)] = 1'b1;
      endcase
      dur = $urandom_range(30, 200);
      for (int i = 0; i < dur; i++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        ovf_clr   = ($urandom_range(0, 31) == 0);
        @(negedge clk);
      end
    end
    keys      = '0;
    ovf_clr   = 1'b0;
    key_ready = 1'b1;
    cycles(4 * SCAN);

    // Reset while three events are queued and the scanner is in CHECK.
    key_ready = 1'b0;
    keys = 16'h000E;
    cycles(150);
    keys = '0;
    cycles(150);
    check("mr_queued", key_valid, 1'b1);
    for (int w = 0; w < 2 * PERIOD && (m_n % PERIOD) != SCAN_DIV + 1; w++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mr_key_valid", key_valid, 1'b0);
    check("mr_key_code", key_code, 4'd0);
    check("mr_key_down", key_down, 16'h0000);
    check("mr_col_out", col_out, 4'b1110);
    check("mr_overflow", overflow, 1'b0);
    cycles(3);
    key_ready = 1'b1;
    rst = 1'b0;
    run_col_table();
    check("mr_empty_after", key_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation did not reach its end (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
